// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and its clock generator.
package spi_pkg;

    localparam int SPI_DATA_W          = 8;
    localparam int SPI_DEFAULT_CLK_DIV = 4;

    // Transfer sequencing: chip-select setup, eight SCLK periods, chip-select hold.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK divider: counts CLK_DIV system cycles per phase and strobes the phase
// boundaries. The counter reloads on wrap, so every SCLK phase is exactly
// CLK_DIV cycles long. While sclk_en is low, phases still elapse (for the
// SETUP/HOLD timing) but sclk stays low.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sclk_en,
    output logic phase_tick,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             sclk_reg;

    // A strobe is high in the last cycle of a phase; the edge itself lands on the next clk edge.
    assign phase_tick = en && (cnt_reg == CNT_LAST);
    assign rise_tick  = phase_tick && sclk_en && !sclk_reg;
    assign fall_tick  = phase_tick && sclk_en && sclk_reg;
    assign sclk       = sclk_reg;

    // Phase counter and SCLK level; both park at zero whenever the divider is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b0;
        end else if (!en) begin
            cnt_reg  <= '0;
            sclk_reg <= 1'b0;
        end else if (phase_tick) begin
            cnt_reg <= '0;
            if (sclk_en) begin
                sclk_reg <= ~sclk_reg;
            end
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master, one byte per transfer, LSB-first by default.
// Define SPI_MASTER_MSB_FIRST_EN to shift MSB-first on both mosi and miso;
// timing is identical in both builds.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk,
    output logic              cs,
    output logic              mosi,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

`ifdef SPI_MASTER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    spi_state_t        state_reg;
    logic [DATA_W-1:0] tx_sh_reg;
    logic [DATA_W-1:0] rx_sh_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic              cs_reg;
    logic              mosi_reg;
    logic              busy_reg;
    logic              done_reg;

    logic              phase_tick;
    logic              rise_tick;
    logic              fall_tick;
    logic              clk_en;
    logic              sclk_en;
    logic [DATA_W-1:0] rx_sh_next;

    // The divider runs for the whole transfer; SCLK toggles only between SETUP entry and the eighth fall.
    assign clk_en  = (state_reg != IDLE);
    assign sclk_en = (state_reg == SETUP) || (state_reg == XFER);

    // miso is taken as-is (X/Z included) and shifted toward the end that receives the first bit.
    assign rx_sh_next = MSB_FIRST ? {rx_sh_reg[DATA_W-2:0], miso}
                                  : {miso, rx_sh_reg[DATA_W-1:1]};

    spi_clk_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (clk_en),
        .sclk_en    (sclk_en),
        .phase_tick (phase_tick),
        .rise_tick  (rise_tick),
        .fall_tick  (fall_tick),
        .sclk       (sclk)
    );

    // Transfer FSM with registered cs/mosi/busy/done/rx_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            tx_sh_reg   <= '0;
            rx_sh_reg   <= '0;
            rx_data_reg <= '0;
            bit_cnt_reg <= '0;
            cs_reg      <= 1'b1;
            mosi_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // First bit goes straight to mosi; the remainder waits in tx_sh.
                        if (MSB_FIRST) begin
                            mosi_reg  <= tx_data[DATA_W-1];
                            tx_sh_reg <= {tx_data[DATA_W-2:0], 1'b0};
                        end else begin
                            mosi_reg  <= tx_data[0];
                            tx_sh_reg <= {1'b0, tx_data[DATA_W-1:1]};
                        end
                        cs_reg      <= 1'b0;
                        busy_reg    <= 1'b1;
                        bit_cnt_reg <= '0;
                        state_reg   <= SETUP;
                    end
                end
                SETUP: begin
                    // The end of SETUP is the first rising SCLK edge.
                    if (rise_tick) begin
                        rx_sh_reg <= rx_sh_next;
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    if (rise_tick) begin
                        rx_sh_reg <= rx_sh_next;
                    end
                    if (fall_tick) begin
                        if (bit_cnt_reg == BIT_LAST) begin
                            // mosi keeps the last bit through HOLD.
                            state_reg <= HOLD;
                        end else begin
                            if (MSB_FIRST) begin
                                mosi_reg  <= tx_sh_reg[DATA_W-1];
                                tx_sh_reg <= {tx_sh_reg[DATA_W-2:0], 1'b0};
                            end else begin
                                mosi_reg  <= tx_sh_reg[0];
                                tx_sh_reg <= {1'b0, tx_sh_reg[DATA_W-1:1]};
                            end
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (phase_tick) begin
                        cs_reg      <= 1'b1;
                        busy_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        rx_data_reg <= rx_sh_reg;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cs      = cs_reg;
    assign mosi    = mosi_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign rx_data = rx_data_reg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master (CLK_DIV=4): loopback, slave model, ignored
// restart, back-to-back transfers, mid-transfer reset and bit order.
module tb_spi_master;

`ifdef SPI_MASTER_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;

    int n_checks = 0;
    int n_errors = 0;

    // Slave model (mode 0, same bit order as the build)
    logic       use_slave = 1'b0;
    logic [7:0] slv_tx = 8'h00;
    logic [7:0] slv_sh = 8'h00;
    logic [7:0] slv_rx = 8'h00;
    logic       slv_bit;

    // Transfer observations
    int   rise_cnt, rise_first, rise_last;
    int   done_cnt, done_first, done_last;
    int   busy_low_first, cs_between;
    logic cs_at1, busy_at1, mosi_first, mosi_last;
    logic [7:0] rx_first, rx_last;

    always #5 clk = ~clk;

    spi_master #(.CLK_DIV(4), .DATA_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .tx_data (tx_data),
        .miso    (miso),
        .sclk    (sclk),
        .cs      (cs),
        .mosi    (mosi),
        .busy    (busy),
        .done    (done),
        .rx_data (rx_data)
    );

    assign slv_bit = MSB ? slv_sh[7] : slv_sh[0];
    assign miso    = use_slave ? (cs ? 1'b0 : slv_bit) : mosi;

    always @(negedge cs) slv_sh = slv_tx;
    always @(posedge sclk) if (!cs) slv_rx = MSB ? {slv_rx[6:0], mosi} : {mosi, slv_rx[7:1]};
    always @(negedge sclk) if (!cs) slv_sh = MSB ? {slv_sh[6:0], 1'b0} : {1'b0, slv_sh[7:1]};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one transfer (start sampled at edge 0), then observe cycles 1..ncyc.
    task automatic run_xfer(input logic [7:0] tx, input logic [7:0] tx2, input int ncyc,
                            input int pulse_cyc, input bit hold);
        logic prev_sclk;
        prev_sclk = 1'b0;
        rise_cnt = 0; rise_first = 0; rise_last = 0;
        done_cnt = 0; done_first = 0; done_last = 0;
        busy_low_first = 0; cs_between = 0;
        rx_first = 8'h00; rx_last = 8'h00; mosi_last = 1'b0;
        tx_data = tx;
        start = 1'b1;
        step();
        if (!hold) start = 1'b0;
        tx_data = hold ? tx2 : ~tx;
        cs_at1 = cs; busy_at1 = busy; mosi_first = mosi;
        for (int c = 1; c <= ncyc; c++) begin
            if (sclk && !prev_sclk) begin
                rise_cnt++;
                if (rise_first == 0) rise_first = c;
                rise_last = c;
                mosi_last = mosi;
            end
            prev_sclk = sclk;
            if (done) begin
                done_cnt++;
                if (done_first == 0) begin
                    done_first = c;
                    rx_first = rx_data;
                end
                done_last = c;
                rx_last = rx_data;
            end
            if (!busy && busy_low_first == 0) busy_low_first = c;
            if (done_cnt == 1 && cs) cs_between++;
            if (c == pulse_cyc) start = 1'b1;
            else if (pulse_cyc > 0 && c == pulse_cyc + 1) start = 1'b0;
            if (hold && done_cnt == 1 && !cs) start = 1'b0;
            step();
        end
        $display("xfer tx=%02h rises=%0d first_rise=%0d done_at=%0d dones=%0d rx=%02h",
                 tx, rise_cnt, rise_first, done_first, done_cnt, rx_first);
    endtask

    initial begin
        int dn;
        #2 rst_n = 1'b0;
        #1;
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_cs", 32'(cs), 32'd1);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx", 32'(rx_data), 32'h00);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Loopback A5
        run_xfer(8'hA5, 8'h00, 75, 0, 1'b0);
        check("a5_cs_c1", 32'(cs_at1), 32'd0);
        check("a5_busy_c1", 32'(busy_at1), 32'd1);
        check("a5_mosi_c1", 32'(mosi_first), 32'd1);
        check("a5_rises", 32'(rise_cnt), 32'd8);
        check("a5_first_rise", 32'(rise_first), 32'd5);
        check("a5_last_rise", 32'(rise_last), 32'd61);
        check("a5_done_cyc", 32'(done_first), 32'd69);
        check("a5_done_cnt", 32'(done_cnt), 32'd1);
        check("a5_busy_low", 32'(busy_low_first), 32'd69);
        check("a5_rx", 32'(rx_first), 32'hA5);
        check("a5_rx_hold", 32'(rx_data), 32'hA5);
        check("a5_cs_end", 32'(cs), 32'd1);

        // Slave model: master sends 3C, slave returns C3
        use_slave = 1'b1;
        slv_tx = 8'hC3;
        slv_rx = 8'h00;
        run_xfer(8'h3C, 8'h00, 75, 0, 1'b0);
        check("slv_master_rx", 32'(rx_first), 32'hC3);
        check("slv_slave_rx", 32'(slv_rx), 32'h3C);
        use_slave = 1'b0;

        // Restart pulse at cycle 20 is ignored
        run_xfer(8'h5A, 8'h00, 90, 20, 1'b0);
        check("ign_done_cnt", 32'(done_cnt), 32'd1);
        check("ign_done_cyc", 32'(done_first), 32'd69);
        check("ign_busy_low", 32'(busy_low_first), 32'd69);
        check("ign_rx", 32'(rx_first), 32'h5A);

        // start held high: 01 then 80 back to back
        run_xfer(8'h01, 8'h80, 145, 0, 1'b1);
        check("b2b_dones", 32'(done_cnt), 32'd2);
        check("b2b_gap", 32'(done_last - done_first), 32'd69);
        check("b2b_cs_high", 32'(cs_between), 32'd1);
        check("b2b_rx1", 32'(rx_first), 32'h01);
        check("b2b_rx2", 32'(rx_last), 32'h80);

        // Bit order with tx=01 in loopback
        run_xfer(8'h01, 8'h00, 75, 0, 1'b0);
        check("ord_first_bit", 32'(mosi_first), MSB ? 32'd0 : 32'd1);
        check("ord_last_bit", 32'(mosi_last), MSB ? 32'd1 : 32'd0);
        check("ord_rx", 32'(rx_first), 32'h01);

        // Reset at cycle 30 of a transfer
        tx_data = 8'h5A;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 30; c++) step();
        check("mid_sclk_pre", 32'(sclk), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sclk", 32'(sclk), 32'd0);
        check("mid_rst_cs", 32'(cs), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rx", 32'(rx_data), 32'h00);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 80; c++) begin
            if (done) dn++;
            step();
        end
        check("mid_no_done", 32'(dn), 32'd0);
        check("mid_rx_after", 32'(rx_data), 32'h00);
        $display("xfer tx=5a aborted by reset at cycle 30 dones=%0d rx=%02h", dn, rx_data);

        // First start after reset is accepted immediately
        run_xfer(8'hA5, 8'h00, 75, 0, 1'b0);
        check("post_rst_done", 32'(done_first), 32'd69);
        check("post_rst_rx", 32'(rx_first), 32'hA5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clk cycles; legal range is 2..255.
REQ-002 The block SHALL have parameter DATA_W, default 8, giving bits per transfer; it is fixed at 8.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request for one transfer; sampled only while idle.
REQ-006 tx_data  input  8  byte to shift out on mosi; captured when start is accepted.
REQ-007 miso  input  1  serial data from the slave; may be high-Z when the slave is deselected.
REQ-008 sclk  output  1  SPI clock, mode 0 (idles low).
REQ-009 cs  output  1  chip select, active low.
REQ-010 mosi  output  1  serial data to the slave.
REQ-011 busy  output  1  high from the cycle after start is accepted until done.
REQ-012 done  output  1  one-cycle pulse at transfer end.
REQ-013 rx_data  output  8  last received byte; valid from the done pulse until the next done.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, XFER and HOLD.
REQ-015 IDLE -> SETUP when start=1 (cycle 0): capture tx_data, drive cs low from cycle 1, and drive mosi = bit 0 from cycle 1.
REQ-016 SETUP SHALL last CLK_DIV cycles with sclk low, then move to XFER.
REQ-017 XFER SHALL produce 8 SCLK periods of 2*CLK_DIV cycles each: rising edges at cycles 1+CLK_DIV+2*CLK_DIV*k and falling edges CLK_DIV later, for k=0..7.
REQ-018 On each rising edge, the block SHALL sample miso into the receive shift register; data is LSB-first, so the first sampled bit becomes rx bit 0.
REQ-019 On each falling edge except the eighth, the block SHALL advance mosi to the next tx bit; after the eighth falling edge, mosi SHALL hold its last value.
REQ-020 After the eighth falling edge, the FSM SHALL enter HOLD for CLK_DIV cycles with sclk low and cs low.
REQ-021 At HOLD exit (cycle 1+17*CLK_DIV), cs SHALL go high, busy SHALL go low, done SHALL pulse, rx_data SHALL update, and the FSM SHALL return to IDLE; for CLK_DIV=4 this is cycle 69.
REQ-022 start asserted while busy SHALL be ignored, with no queuing.
REQ-023 start held high continuously SHALL begin a new transfer in the cycle after done, so cs is high for exactly one cycle between transfers.
REQ-024 rx_data SHALL change only on the done cycle, and tx_data changes after acceptance SHALL have no effect.
REQ-025 A miso value of X/Z SHALL be sampled as-is; the block SHALL add no resolution logic.
REQ-026 The divider counter SHALL be ceil(log2(CLK_DIV)) bits wide and reload on wrap, so sclk has no glitches or short phases.

Reset
REQ-027 When rst_n=0, the block SHALL immediately force sclk=0, cs=1, mosi=0, busy=0, done=0, rx_data=8'h00, the FSM to IDLE, and all counters to 0.
REQ-028 A reset asserted mid-transfer SHALL abort it: no done pulse and no rx_data update.
REQ-029 After rst_n rises, the first start SHALL be accepted on the first clk edge at which it is sampled high.

Configuration
REQ-030 When macro SPI_MASTER_MSB_FIRST_EN is defined, bit order SHALL be MSB-first on both mosi (first bit tx_data[7]) and miso (first sampled bit goes to rx_data[7]).
REQ-031 When SPI_MASTER_MSB_FIRST_EN is undefined, bit order SHALL be LSB-first per REQ-015 and REQ-018; all timing is identical in both builds.

Structure
REQ-032 Package spi_pkg SHALL hold the FSM state enum (IDLE, SETUP, XFER, HOLD), the constant SPI_DATA_W=8, and the constant SPI_DEFAULT_CLK_DIV=4.
REQ-033 Sub-module spi_clk_gen SHALL own the divider and emit one-cycle rise_tick/fall_tick strobes plus the sclk level; spi_master SHALL own the FSM, bit counter and shift registers.

Verification
REQ-034 The bench SHALL cover: CLK_DIV=4, tx_data=8'hA5, miso looped to mosi -> cs low at cycle 1, 8 sclk rising edges at cycles 5,13,...,61, done at cycle 69, rx_data=8'hA5.
REQ-035 The bench SHALL cover: tx_data=8'h3C connected to an 8-bit LSB-first mode-0 slave model preloaded with 8'hC3 -> master rx_data=8'hC3, slave receives 8'h3C.
REQ-036 The bench SHALL cover: start pulsed again at cycle 20 of a transfer -> ignored, exactly one done, busy stays high until cycle 69.
REQ-037 The bench SHALL cover: start held high for two transfers of 8'h01 and 8'h80 -> cs high for exactly one cycle between them, and two done pulses 69 cycles apart.
REQ-038 The bench SHALL cover: rst_n low at cycle 30 -> sclk=0, cs=1, busy=0 immediately, no done pulse, rx_data=8'h00.
REQ-039 The bench SHALL cover: SPI_MASTER_MSB_FIRST_EN defined, tx_data=8'h01 -> first mosi bit is 0 and the last bit is 1, and loopback gives rx_data=8'h01.
